// File: rtl/jeff_tdm_demux_1to2_if.sv
// Bus bundle for the 1-to-2 TDM demultiplexer: word input side, demultiplexed
// pair output side and a debug view of the slot FSM.
interface jeff_tdm_demux_1to2_if #(
    parameter int WIDTH = 4
);
    // Handshake: in_valid qualifies din and sof in the same cycle. There is no
    // ready: while en=1 every valid word is consumed on the rising edge, and
    // en=0 makes the block ignore the input side entirely. out_valid and err
    // are single-cycle pulses with no back-pressure.
    logic             en;
    logic [WIDTH-1:0] din;
    logic             in_valid;
    logic             sof;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             sel;
    logic             err;
    logic [7:0]       frame_cnt;
    logic             state_dbg;

    modport master (
        output en,
        output din,
        output in_valid,
        output sof,
        input  a,
        input  b,
        input  out_valid,
        input  sel,
        input  err,
        input  frame_cnt,
        input  state_dbg
    );

    modport slave (
        input  en,
        input  din,
        input  in_valid,
        input  sof,
        output a,
        output b,
        output out_valid,
        output sel,
        output err,
        output frame_cnt,
        output state_dbg
    );
endinterface

// File: rtl/jeff_tdm_demux_1to2.sv
// Splits a time-multiplexed A/B word stream (sof tags the A slot) into a
// registered A/B pair, with sync-error detection and a wrapping frame counter.
module jeff_tdm_demux_1to2 #(
    parameter int WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    jeff_tdm_demux_1to2_if.slave          bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GOT_A = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_hold;
    logic [WIDTH-1:0] a_hold_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] a_nxt;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] b_nxt;
    logic             out_valid_q;
    logic             out_valid_nxt;
    logic             err_q;
    logic             err_nxt;
    logic [7:0]       frame_cnt_q;
    logic [7:0]       frame_cnt_nxt;
    logic             accept;

    // en=0 blocks acceptance; since every next-value defaults to "hold",
    // that alone freezes the whole block and lets both pulses fall to 0.
    assign accept = bus.en && bus.in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a_hold      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state       <= state_nxt;
            a_hold      <= a_hold_nxt;
            a_q         <= a_nxt;
            b_q         <= b_nxt;
            out_valid_q <= out_valid_nxt;
            err_q       <= err_nxt;
            frame_cnt_q <= frame_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        a_hold_nxt    = a_hold;
        a_nxt         = a_q;
        b_nxt         = b_q;
        out_valid_nxt = 1'b0;
        err_nxt       = 1'b0;
        frame_cnt_nxt = frame_cnt_q;

        unique case (state)
            IDLE: begin
                // Untagged words while hunting are B words of a lost frame.
                if (accept && bus.sof) begin
                    a_hold_nxt = bus.din;
                    state_nxt  = GOT_A;
                end
            end
            GOT_A: begin
                if (accept) begin
                    if (bus.sof) begin
                        // Resync on the newest A word; outputs stay untouched.
                        err_nxt    = 1'b1;
                        a_hold_nxt = bus.din;
                    end else begin
                        a_nxt         = a_hold;
                        b_nxt         = bus.din;
                        out_valid_nxt = 1'b1;
                        frame_cnt_nxt = frame_cnt_q + 8'd1;
                        state_nxt     = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.out_valid = out_valid_q;
    assign bus.err       = err_q;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.sel       = (state == GOT_A);
    assign bus.state_dbg = state;

endmodule
